conv_window_gen: RTL and testbench

- Parametrised successor to the fixed 3x3 pixel shift register in the image-filter datapath.
- Streams a raster image in one pixel per accepted beat and buffers K-1 full rows in line buffers.
- Emits every fully-interior KxK window with its top-left coordinates, using valid/ready handshakes on both sides.
- Contains its own frame-size registers, row/column counters and control FSM, so the downstream arithmetic block only consumes windows.

---
 rtl/conv_window_gen.sv | 178 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator for a raster pixel stream.
// K-1 line buffers feed K column shift registers; the window appears one cycle after its bottom-right pixel.
module conv_window_gen #(
    parameter int PIX_W    = 8,
    parameter int K        = 3,
    parameter int MAX_COLS = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [CNT_W-1:0]       cfg_cols,
    input  logic [CNT_W-1:0]       cfg_rows,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [PIX_W-1:0]       in_data,
    output logic                   in_ready,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [K*K*PIX_W-1:0]   win_data,
    output logic [CNT_W-1:0]       win_row,
    output logic [CNT_W-1:0]       win_col,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   cfg_error
);

    localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_K   = CNT_W'(K);
    localparam logic [CNT_W-1:0] C_KM1 = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_COLS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cols;
    logic [CNT_W-1:0]   r_rows;
    logic [CNT_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_col;
    logic               r_cfg_error;
    logic               r_win_valid;
    logic [CNT_W-1:0]   r_win_row;
    logic [CNT_W-1:0]   r_win_col;
    logic [PIX_W-1:0]   r_lb  [K-1][MAX_COLS];
    logic [PIX_W-1:0]   r_win [K][K];
    logic [PIX_W-1:0]   w_col [K];
    logic [AW-1:0]      w_addr;
    logic               w_accept;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_win_load;

    assign w_addr     = r_col[AW-1:0];
    assign w_accept   = in_valid & in_ready;
    assign w_last_col = (r_col == r_cols - C_ONE);
    assign w_last_row = (r_row == r_rows - C_ONE);
    assign w_win_load = w_accept & (r_row >= C_KM1) & (r_col >= C_KM1);

    // Column entering the window: oldest row from line buffer 0, newest row is the live pixel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_col = '{default: '0};
        for (int k = 0; k < K - 1; k++) begin
            w_col[k] = r_lb[k][w_addr];
        end
        w_col[K-1] = in_data;
    end

    // NOTE: line-buffer storage is deliberately not reset; its contents are overwritten before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < K - 2; k++) begin
                r_lb[k][w_addr] <= r_lb[k+1][w_addr];
            end
            r_lb[K-2][w_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            // NOTE: non-blocking assignments let every stage shift from its pre-edge neighbour.
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_col[r];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_data[(r*K+c)*PIX_W +: PIX_W] = r_win[r][c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + C_ONE;
            end else begin
                r_col <= r_col + C_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else if (w_win_load) begin
            r_win_valid <= 1'b1;
            r_win_row   <= r_row - C_KM1;
            r_win_col   <= r_col - C_KM1;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cols      <= '0;
            r_rows      <= '0;
            r_cfg_error <= 1'b0;
        end else if (cfg_load && r_state == S_IDLE) begin
            r_cols      <= cfg_cols;
            r_rows      <= cfg_rows;
            r_cfg_error <= (cfg_cols < C_K) | (cfg_rows < C_K) | (cfg_cols > C_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && !r_cfg_error) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last_col && w_last_row) w_next = S_FLUSH;
            S_FLUSH: if (r_win_valid && win_ready) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        frame_done = (r_state == S_DONE);
        in_ready   = (r_state == S_RUN) & (~r_win_valid | win_ready);
    end

    assign win_valid = r_win_valid;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;
    assign cfg_error = r_cfg_error;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: K=3/8-bit instance for most scenarios, K=5/10-bit instance for the wide window.
module tb_conv_window_gen;

    localparam int PW  = 8;
    localparam int KK  = 3;
    localparam int MC  = 1024;
    localparam int CW  = 16;
    localparam int WW  = KK*KK*PW;
    localparam int PW1 = 10;
    localparam int K1  = 5;
    localparam int WW1 = K1*K1*PW1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic cfg_load0, start0, in_valid0, in_ready0, win_valid0, win_ready0, busy0, frame_done0, cfg_error0;
    logic [CW-1:0] cfg_cols0, cfg_rows0, win_row0, win_col0;
    logic [PW-1:0] in_data0;
    logic [WW-1:0] win_data0;

    logic cfg_load1, start1, in_valid1, in_ready1, win_valid1, win_ready1, busy1, frame_done1, cfg_error1;
    logic [CW-1:0] cfg_cols1, cfg_rows1, win_row1, win_col1;
    logic [PW1-1:0] in_data1;
    logic [WW1-1:0] win_data1;

    conv_window_gen #(.PIX_W(PW), .K(KK), .MAX_COLS(MC), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load0), .cfg_cols(cfg_cols0), .cfg_rows(cfg_rows0),
        .start(start0), .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
        .win_valid(win_valid0), .win_ready(win_ready0), .win_data(win_data0),
        .win_row(win_row0), .win_col(win_col0), .busy(busy0), .frame_done(frame_done0),
        .cfg_error(cfg_error0)
    );

    conv_window_gen #(.PIX_W(PW1), .K(K1), .MAX_COLS(64), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load1), .cfg_cols(cfg_cols1), .cfg_rows(cfg_rows1),
        .start(start1), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .win_valid(win_valid1), .win_ready(win_ready1), .win_data(win_data1),
        .win_row(win_row1), .win_col(win_col1), .busy(busy1), .frame_done(frame_done1),
        .cfg_error(cfg_error1)
    );

    typedef struct packed {
        logic [WW-1:0] data;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } win0_t;

    typedef struct packed {
        logic [WW1-1:0] data;
        logic [CW-1:0]  row;
        logic [CW-1:0]  col;
    } win1_t;

    win0_t q0[$];
    win1_t q1[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int first_cyc, last_cyc, hs_cnt, done_cnt, hs1, done1;
    bit rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix0(input int r, input int c, input int cols);
        return PW'(r*cols + c);
    endfunction

    task automatic push_frame0(input int cols, input int rows);
        win0_t w;
        for (int r = 0; r <= rows - KK; r++) begin
            for (int c = 0; c <= cols - KK; c++) begin
                w.data = '0;
                for (int rr = 0; rr < KK; rr++)
                    for (int cc = 0; cc < KK; cc++)
                        w.data[(rr*KK+cc)*PW +: PW] = pix0(r+rr, c+cc, cols);
                w.row = CW'(r);
                w.col = CW'(c);
                q0.push_back(w);
            end
        end
    endtask

    // ready generator for the K=3 instance
    initial begin
        win_ready0 = 1'b1;
        forever begin
            @(negedge clk);
            win_ready0 = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor / scoreboard for the K=3 instance; samples just before each rising edge
    initial begin
        bit            held;
        logic [WW-1:0] h_data;
        logic [CW-1:0] h_row, h_col;
        win0_t         w;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_data", win_data0, h_data);
                    check("hold_row", win_row0, h_row);
                    check("hold_col", win_col0, h_col);
                end
                if (win_valid0 && !win_ready0) begin
                    check("stall_in_ready", in_ready0, 1'b0);
                    held = 1'b1;
                    h_data = win_data0;
                    h_row = win_row0;
                    h_col = win_col0;
                end else begin
                    held = 1'b0;
                end
                if (win_valid0 && win_ready0) begin
                    if (q0.size() == 0) begin
                        check("unexpected_window", 1'b1, 1'b0);
                    end else begin
                        w = q0.pop_front();
                        check("win_data", win_data0, w.data);
                        check("win_row", win_row0, w.row);
                        check("win_col", win_col0, w.col);
                    end
                    if (hs_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    hs_cnt++;
                end
                if (frame_done0) begin
                    check("done_after_last_handoff", cyc, last_cyc + 1);
                    check("done_queue_empty", q0.size(), 0);
                    done_cnt++;
                end
            end
        end
    end

    // monitor for the K=5 instance
    initial begin
        win1_t w;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && win_valid1 && win_ready1) begin
                if (q1.size() == 0) begin
                    check("k5_unexpected_window", 1'b1, 1'b0);
                end else begin
                    w = q1.pop_front();
                    check("k5_win_data", win_data1, w.data);
                    check("k5_win_row", win_row1, w.row);
                    check("k5_win_col", win_col1, w.col);
                    if (w.row == 1 && w.col == 1) begin
                        check("k5_elem0", win_data1[0 +: PW1], 7);
                        check("k5_elem24", win_data1[24*PW1 +: PW1], 35);
                    end
                end
                hs1++;
            end
            if (!rst && frame_done1) done1++;
        end
    end

    task automatic load_cfg0(input int cols, input int rows);
        cfg_load0 = 1'b1;
        cfg_cols0 = CW'(cols);
        cfg_rows0 = CW'(rows);
        @(negedge clk);
        cfg_load0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_pix0(input logic [PW-1:0] d, input bit gaps);
        bit acc;
        acc = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid0 = 1'b0;
            @(negedge clk);
        end
        in_valid0 = 1'b1;
        in_data0 = d;
        for (int t = 0; t < 200 && !acc; t++) begin
            #4;
            acc = in_ready0;
            @(negedge clk);
        end
        if (!acc) check("in_ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic start_frame0(input int cols, input int rows);
        done_cnt = 0;
        hs_cnt = 0;
        push_frame0(cols, rows);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("busy_after_start", busy0, 1'b1);
    endtask

    task automatic run_frame0(input int cols, input int rows, input bit rnd);
        bit seen;
        rdy_rand = rnd;
        start_frame0(cols, rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                send_pix0(pix0(r, c, cols), rnd);
        in_valid0 = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            seen = (done_cnt > 0);
        end
        if (!seen) check("frame_done_timeout", 1'b0, 1'b1);
        check("busy_after_done", busy0, 1'b0);
        check("frame_done_count", done_cnt, 1);
        check("windows_in_frame", hs_cnt, (rows-KK+1)*(cols-KK+1));
        check("queue_drained", q0.size(), 0);
        rdy_rand = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win_valid"}, win_valid0, 1'b0);
        check({tag, "_in_ready"}, in_ready0, 1'b0);
        check({tag, "_busy"}, busy0, 1'b0);
        check({tag, "_frame_done"}, frame_done0, 1'b0);
        check({tag, "_cfg_error"}, cfg_error0, 1'b0);
        check({tag, "_win_data"}, win_data0, '0);
        check({tag, "_win_row"}, win_row0, '0);
        check({tag, "_win_col"}, win_col0, '0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_load0 = 1'b0; cfg_cols0 = '0; cfg_rows0 = '0; start0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0;
        cfg_load1 = 1'b0; cfg_cols1 = '0; cfg_rows1 = '0; start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
        win_ready1 = 1'b1;
        hs_cnt = 0; done_cnt = 0; hs1 = 0; done1 = 0; first_cyc = 0; last_cyc = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 5x4 frame, always ready
        load_cfg0(5, 4);
        check("cfg_5x4_ok", cfg_error0, 1'b0);
        run_frame0(5, 4, 1'b0);

        // same frame with random backpressure and input gaps
        run_frame0(5, 4, 1'b1);

        // illegal width: start must be ignored
        load_cfg0(2, 10);
        check("cfg_2x10_error", cfg_error0, 1'b1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("busy_on_bad_cfg", busy0, 1'b0);
        end
        load_cfg0(MC + 1, 3);
        check("cfg_too_wide_error", cfg_error0, 1'b1);
        load_cfg0(3, 3);
        check("cfg_3x3_ok", cfg_error0, 1'b0);
        run_frame0(3, 3, 1'b0);

        // reset after 7 accepted pixels
        load_cfg0(5, 4);
        start_frame0(5, 4);
        for (int i = 0; i < 7; i++) send_pix0(pix0(i / 5, i % 5, 5), 1'b0);
        in_valid0 = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", done_cnt, 0);
        check("idle_after_reset", busy0, 1'b0);
        load_cfg0(5, 4);
        run_frame0(5, 4, 1'b0);

        // full-width frame, continuous streaming
        load_cfg0(MC, 3);
        check("cfg_max_ok", cfg_error0, 1'b0);
        run_frame0(MC, 3, 1'b0);
        check("no_bubbles", last_cyc - first_cyc, MC - 3);

        // K=5, 10-bit pixels, 6x6 frame
        cfg_load1 = 1'b1;
        cfg_cols1 = CW'(6);
        cfg_rows1 = CW'(6);
        @(negedge clk);
        cfg_load1 = 1'b0;
        @(negedge clk);
        check("k5_cfg_ok", cfg_error1, 1'b0);
        for (int r = 0; r <= 1; r++) begin
            for (int c = 0; c <= 1; c++) begin
                win1_t w;
                w.data = '0;
                for (int rr = 0; rr < K1; rr++)
                    for (int cc = 0; cc < K1; cc++)
                        w.data[(rr*K1+cc)*PW1 +: PW1] = PW1'((r+rr)*6 + c + cc);
                w.row = CW'(r);
                w.col = CW'(c);
                q1.push_back(w);
            end
        end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 36; i++) begin
            bit acc;
            acc = 1'b0;
            in_valid1 = 1'b1;
            in_data1 = PW1'(i);
            for (int t = 0; t < 50 && !acc; t++) begin
                #4;
                acc = in_ready1;
                @(negedge clk);
            end
            if (!acc) check("k5_in_ready_timeout", 1'b0, 1'b1);
        end
        in_valid1 = 1'b0;
        for (int t = 0; t < 50 && done1 == 0; t++) @(negedge clk);
        check("k5_frame_done", done1, 1);
        check("k5_window_count", hs1, 4);
        check("k5_queue_drained", q1.size(), 0);
        check("k5_busy_after_done", busy1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
